pe_answer_initiator: RTL
========================

// Module: pe_answer_initiator
// PURPOSE
//  Compute-pool-side initiator for the fixed-latency PE "answer" interface; the other end of the PE wrappers.
//  Takes per-lane requests (addr + id) from the pool scheduler and drives ans_addr_valid/ans_addr into a PE wrapper.
//  Collects ans_data_valid/ans_data and returns in-order {id,data} responses on a valid/ready stream.
//  Credit accounting means the PE is never issued more work than the response buffer can absorb; PE output cannot stall.
// PARAMETERS
//  NUM_INTERFACES     1   independent lanes; all lanes are fully independent.
//  INPUT_DATA_WIDTH   16  request address/operand width.
//  OUTPUT_DATA_WIDTH  16  PE result width.
//  ID_WIDTH           4   request tag width, returned with the result.
//  ELEMENT_LATENCY    1   PE latency in cycles, >=1.
//  FIFO_DEPTH         4   per-lane tag/result buffer depth, power of 2, >= ELEMENT_LATENCY+1.
// PORTS
//  clk             in   1        clock
//  rst             in   1        synchronous active-low reset
//  req_valid       in   N        per-lane request valid
//  req_ready       out  N        per-lane request accept
//  req_addr        in   N*IDW    packed lane operands
//  req_id          in   N*IDTW   packed lane tags
//  pe_addr_valid   out  N        to PE ans_addr_valid
//  pe_addr         out  N*IDW    to PE ans_addr
//  pe_processing   in   N        from PE ans_processing
//  pe_data_valid   in   N        from PE ans_data_valid
//  pe_data         in   N*ODW    from PE ans_data
//  rsp_valid       out  N        response valid
//  rsp_ready       in   N        response accept
//  rsp_data        out  N*ODW    result
//  rsp_id          out  N*IDTW   tag of result
//  err_spurious    out  N        sticky: pe_data_valid with no request outstanding
//  err_latency     out  N        sticky latency mismatch (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst==0 at clk edge): FIFOs empty, counters 0, rsp_valid=0, err_*=0. Reset mid-flight discards in-flight tags.
//  Reset also drops PE results arriving after reset; they do not raise err_spurious during the first ELEMENT_LATENCY cycles.
//  Credit: reserved = inflight + result_count; req_ready = pe_processing & (reserved < FIFO_DEPTH).
//  Issue (combinational): pe_addr_valid = req_valid & req_ready; pe_addr = req_addr. On issue, push req_id to tag FIFO; inflight++.
//  Return: on pe_data_valid, pop tag FIFO; push {tag,pe_data} to result FIFO; inflight--.
//  Same-cycle issue + return: inflight unchanged. Same-cycle push + pop on result FIFO: count unchanged, legal at full.
//  rsp_valid = result FIFO not empty; pop on rsp_valid & rsp_ready; rsp_* is the FIFO head, stable while rsp_valid & !rsp_ready.
//  Latency: request accepted at cycle T -> rsp_valid at T+ELEMENT_LATENCY+1, if the FIFO was empty.
//  Throughput: 1 req/cycle/lane while rsp_ready=1.
//  pe_data_valid with tag FIFO empty: result dropped, err_spurious set until reset; counters unchanged.
//  reserved never exceeds FIFO_DEPTH, so result FIFO overflow is structurally impossible (SVA asserted).
//  Order: responses are strictly in issue order per lane; no cross-lane ordering.
// CONFIGURATION
//  `PE_INITIATOR_LATENCY_CHECK_EN defined: per-lane ELEMENT_LATENCY-deep shift register of issue pulses.
//   When its tail != pe_data_valid in a cycle, err_latency is set (sticky until reset).
//  Undefined: no checker logic; err_latency tied 0.
// STRUCTURE
//  pe_initiator_pkg: rsp_entry_t struct {id,data}, count-width localparam $clog2(FIFO_DEPTH)+1, lane slice helpers.
//  Sub-module pe_initiator_fifo: sync FIFO, parameterised width/depth, with count output and same-cycle push/pop.
//  Per lane, generate two FIFO instances: tag and result.
// TESTING
//  1 N=1, L=1: req addr=0x0010 id=3, rsp_ready=1; PE model returns addr+1 -> rsp_valid at T+2, data=0x0011, id=3.
//  2 Back-to-back ids 0..7, rsp_ready=1 -> 8 responses, in order, 1/cycle after a 2-cycle fill.
//  3 rsp_ready=0, DEPTH=4, L=2 -> exactly 4 accepted, req_ready=0; release -> 4 rsp in order, no loss.
//  4 pe_processing=0 for 3 cycles with req_valid=1 -> no pe_addr_valid; resumes the cycle after pe_processing=1.
//  5 Inject pe_data_valid with nothing outstanding -> err_spurious=1, rsp_valid stays 0; with EN, L=2 PE answering in 3 -> err_latency=1.
//  6 rst=0 with 3 in flight, release -> all outputs 0; new req id=5 -> single rsp id=5.

Source files
------------

// File: rtl/pe_initiator_pkg.sv
// Shared types and helpers for the PE answer-interface initiator.
// Latency: none; declarations only.
// Backpressure: none; declarations only.
package pe_initiator_pkg;

  // Field widths of the default lane configuration.
  localparam int DEF_ID_WIDTH   = 4;
  localparam int DEF_DATA_WIDTH = 16;

  // Result-buffer entry for the default widths. The top builds a same-shaped
  // struct from its own parameters, so non-default widths keep this layout.
  typedef struct packed {
    logic [DEF_ID_WIDTH-1:0]   id;
    logic [DEF_DATA_WIDTH-1:0] data;
  } rsp_entry_t;

  // A count field must be able to represent a completely full buffer.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // LSB position of a lane's field inside a packed multi-lane bus.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/pe_initiator_fifo.sv
// Synchronous FIFO with an occupancy count. Simultaneous push and pop are allowed, including when full.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: a push while full without a pop is ignored; a pop while empty is ignored.
module pe_initiator_fifo
  import pe_initiator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = cnt_width(DEPTH),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  // At full, a same-cycle pop frees the slot that this push then fills.
  assign do_push  = push & (~full | pop);
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pe_answer_initiator.sv
// Drives per-lane requests into a fixed-latency PE and returns in-order {id,data} responses.
// Latency: request accepted at cycle T gives rsp_valid at T+ELEMENT_LATENCY+1 when the buffer is empty.
// Backpressure: credit-based; req_ready drops once in-flight plus buffered results reach FIFO_DEPTH. Optional macro: PE_INITIATOR_LATENCY_CHECK_EN.
module pe_answer_initiator
  import pe_initiator_pkg::*;
#(
  parameter int NUM_INTERFACES    = 1,
  parameter int INPUT_DATA_WIDTH  = 16,
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int ID_WIDTH          = 4,
  parameter int ELEMENT_LATENCY   = 1,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_INTERFACES-1:0]                  req_valid,
  output logic [NUM_INTERFACES-1:0]                  req_ready,
  input  logic [NUM_INTERFACES*INPUT_DATA_WIDTH-1:0] req_addr,
  input  logic [NUM_INTERFACES*ID_WIDTH-1:0]         req_id,
  output logic [NUM_INTERFACES-1:0]                  pe_addr_valid,
  output logic [NUM_INTERFACES*INPUT_DATA_WIDTH-1:0] pe_addr,
  input  logic [NUM_INTERFACES-1:0]                  pe_processing,
  input  logic [NUM_INTERFACES-1:0]                  pe_data_valid,
  input  logic [NUM_INTERFACES*OUTPUT_DATA_WIDTH-1:0] pe_data,
  output logic [NUM_INTERFACES-1:0]                  rsp_valid,
  input  logic [NUM_INTERFACES-1:0]                  rsp_ready,
  output logic [NUM_INTERFACES*OUTPUT_DATA_WIDTH-1:0] rsp_data,
  output logic [NUM_INTERFACES*ID_WIDTH-1:0]         rsp_id,
  output logic [NUM_INTERFACES-1:0]                  err_spurious,
  output logic [NUM_INTERFACES-1:0]                  err_latency
);

  localparam int CW = cnt_width(FIFO_DEPTH);
  localparam int BW = $clog2(ELEMENT_LATENCY + 1);

  typedef struct packed {
    logic [ID_WIDTH-1:0]          id;
    logic [OUTPUT_DATA_WIDTH-1:0] data;
  } rsp_t;

  for (genvar g = 0; g < NUM_INTERFACES; g++) begin : g_lane
    localparam int AL = lane_lo(g, INPUT_DATA_WIDTH);
    localparam int DL = lane_lo(g, OUTPUT_DATA_WIDTH);
    localparam int TL = lane_lo(g, ID_WIDTH);

    logic [CW-1:0]       inflight;
    logic [CW-1:0]       tag_cnt;
    logic [CW-1:0]       res_cnt;
    logic [CW:0]         reserved;
    logic                issue;
    logic                data_live;
    logic                ret;
    logic                tag_empty;
    logic                tag_full;
    logic [ID_WIDTH-1:0] tag_head;
    logic                res_empty;
    logic                res_full;
    logic                res_pop;
    rsp_t                res_in;
    rsp_t                res_head;
    logic [BW-1:0]       blank;
    logic                spur_q;

    // Every accepted request owns a result slot until the response leaves.
    assign reserved  = {1'b0, inflight} + {1'b0, res_cnt};
    assign req_ready[g] = pe_processing[g] & (reserved < (CW+1)'(FIFO_DEPTH));
    assign issue     = req_valid[g] & req_ready[g];
    assign pe_addr_valid[g] = issue;
    assign pe_addr[AL +: INPUT_DATA_WIDTH] = req_addr[AL +: INPUT_DATA_WIDTH];

    // Results in the first ELEMENT_LATENCY cycles after reset belong to
    // requests issued before reset, so they are discarded outright.
    assign data_live = pe_data_valid[g] & (blank == '0);
    assign ret       = data_live & ~tag_empty;
    assign res_pop   = ~res_empty & rsp_ready[g];
    assign res_in    = '{id: tag_head, data: pe_data[DL +: OUTPUT_DATA_WIDTH]};

    pe_initiator_fifo #(.WIDTH(ID_WIDTH), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (issue),
      .push_data (req_id[TL +: ID_WIDTH]),
      .pop       (ret),
      .pop_data  (tag_head),
      .count     (tag_cnt),
      .empty     (tag_empty),
      .full      (tag_full)
    );

    pe_initiator_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(FIFO_DEPTH)) u_res_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (ret),
      .push_data (res_in),
      .pop       (res_pop),
      .pop_data  (res_head),
      .count     (res_cnt),
      .empty     (res_empty),
      .full      (res_full)
    );

    assign rsp_valid[g] = ~res_empty;
    assign rsp_data[DL +: OUTPUT_DATA_WIDTH] = res_head.data;
    assign rsp_id[TL +: ID_WIDTH] = res_head.id;

    // Requests currently inside the PE pipeline.
    always_ff @(posedge clk) begin
      if (!rst) begin
        inflight <= '0;
      end else begin
        case ({issue, ret})
          2'b10:   inflight <= inflight + CW'(1);
          2'b01:   inflight <= inflight - CW'(1);
          default: inflight <= inflight;
        endcase
      end
    end

    // Post-reset window during which stale PE results are ignored.
    always_ff @(posedge clk) begin
      if (!rst) begin
        blank <= BW'(ELEMENT_LATENCY);
      end else if (blank != '0) begin
        blank <= blank - BW'(1);
      end
    end

    // Sticky flag for a PE result with no matching request outstanding.
    always_ff @(posedge clk) begin
      if (!rst) begin
        spur_q <= 1'b0;
      end else if (data_live && tag_empty) begin
        spur_q <= 1'b1;
      end
    end
    assign err_spurious[g] = spur_q;

`ifdef PE_INITIATOR_LATENCY_CHECK_EN
    logic [ELEMENT_LATENCY-1:0] issue_sr;
    logic                       lat_q;

    // Replays issue pulses ELEMENT_LATENCY cycles later and compares them with the PE's valid.
    always_ff @(posedge clk) begin
      if (!rst) begin
        issue_sr <= '0;
        lat_q    <= 1'b0;
      end else begin
        issue_sr <= (issue_sr << 1) | ELEMENT_LATENCY'(issue);
        if ((blank == '0) && (issue_sr[ELEMENT_LATENCY-1] != pe_data_valid[g])) begin
          lat_q <= 1'b1;
        end
      end
    end
    assign err_latency[g] = lat_q;
`else
    assign err_latency[g] = 1'b0;
`endif

    a_no_res_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(ret && res_full && !res_pop));
    a_no_tag_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(issue && tag_full));
    a_reserved_bound: assert property (@(posedge clk) disable iff (!rst)
      reserved <= (CW+1)'(FIFO_DEPTH));
    a_tag_tracks_inflight: assert property (@(posedge clk) disable iff (!rst)
      tag_cnt == inflight);
  end

endmodule
